loopback_controller: RTL and testbench
======================================

# loopback_controller

Run sequencer for the 802.11a transmitter→receiver loopback. On a one-shot `Go` it streams a configurable number of PRBS payload frames into the transmitter (`Start` pulse plus serial `Input`), regenerates the same PRBS to check the receiver's serial `Output` a fixed loop latency later, and accumulates bit, frame and receiver-error statistics. It sits beside the transmitter/receiver pair and replaces hand-driven bench stimulus for BER and regression runs.

## Interface
Parameters:
- FRAME_BITS, 96: payload bits per frame, ≥1
- LOOP_LATENCY, 64: cycles from a bit on TxInput to the same bit on RxOutput, ≥1
- GAP_CYCLES, 16: idle cycles between frames, ≥1

Ports:
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Go  in  1  one-shot run request, honoured only in IDLE
- NumFrames  in  8  frames per run, sampled on accepted Go
- Seed  in  16  PRBS seed, sampled on accepted Go; 0 is replaced by 16'hACE1
- TxStart  out  1  to transmitter Start; one-cycle pulse per frame
- TxInput  out  1  to transmitter Input
- RxOutput  in  1  from receiver Output
- RxError  in  1  from receiver Error
- Busy  out  1  high from accepted Go until DONE
- Done  out  1  level, high in DONE until next accepted Go or Reset
- Pass  out  1  valid while Done: BitErrors==0 and FrameErrors==0
- BitErrors  out  16  mismatched bits this run, saturating at 16'hFFFF
- FramesDone  out  8  frames fully checked this run
- FrameErrors  out  8  frames with ≥1 mismatch or any RxError, saturating at 8'hFF

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: all outputs at reset values except Done/Pass/counters, which hold the previous run's result. Go=1 → latch NumFrames and Seed, clear counters, load both LFSRs with seed, Done←0, Busy←1; NumFrames==0 → DONE (Pass=1), else RUN.
- PRBS: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1; output bit = lfsr[15]; advance: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. The TX LFSR advances once per transmitted bit, the checker LFSR once per checked bit. Both continue across frames within a run; no per-frame reseed.
- RUN: frame cycle counter cyc starts at 0 on entry.
  - cyc==0: TxStart=1.
  - 0 ≤ cyc < FRAME_BITS: TxInput = TX LFSR bit; otherwise TxInput=0.
  - LOOP_LATENCY ≤ cyc < LOOP_LATENCY+FRAME_BITS: compare RxOutput against the checker bit; on mismatch BitErrors+1 (saturating) and set frame-mismatch flag.
  - RxError=1 on any RUN cycle sets the frame-mismatch flag.
  - cyc == LOOP_LATENCY+FRAME_BITS−1 (last compare): FramesDone+1, FrameErrors+1 if flag (flag includes this cycle's compare), clear flag → GAP.
- Send and check windows overlap when LOOP_LATENCY < FRAME_BITS; both are driven from the same cyc.
- GAP: TxStart=0, TxInput=0 for GAP_CYCLES cycles. RxOutput/RxError ignored. Then FramesDone==latched NumFrames → DONE, else RUN.
- DONE: Busy=0, Done=1, Pass per formula, counters frozen. The next cycle returns to IDLE with Done/Pass/counters held.
- Go outside IDLE is ignored; NumFrames/Seed changes mid-run have no effect.

## Timing
- Reset values: TxStart=0, TxInput=0, Busy=0, Done=0, Pass=0, all counters 0, state IDLE, LFSRs = 16'hACE1.
- Reset during any state: the next cycle is IDLE with all reset values; partial-run statistics are discarded.
- Go accepted at edge t → RUN at t+1: TxStart=1 and first payload bit on TxInput in the same cycle.
- Frame length in RUN: LOOP_LATENCY+FRAME_BITS cycles; frame period = that + GAP_CYCLES.
- Run with N frames: Done rises N·(LOOP_LATENCY+FRAME_BITS+GAP_CYCLES)+1 cycles after the Go edge; N=0 → 1 cycle.
- Outputs are registered; counters update the cycle after the compare that causes them.

## Test plan
- Ideal loopback (RxOutput = TxInput delayed 64 cycles, RxError=0), Seed=16'h0001, NumFrames=3 → three TxStart pulses 176 cycles apart, Done after 529 cycles, BitErrors=0, FramesDone=3, Pass=1.
- Same setup with one RxOutput bit inverted in frame 2 → BitErrors=1, FrameErrors=1, Pass=0.
- RxError pulsed for one cycle in frame 1, data correct → BitErrors=0, FrameErrors=1, Pass=0.
- Seed=0 → TxInput sequence identical to a Seed=16'hACE1 run; NumFrames=0 → Done and Pass one cycle after Go, no TxStart.
- Reset asserted mid-frame 2 of 4 → next cycle Busy=0, TxStart=0, counters 0; a new Go then runs 4 clean frames.
- Go re-pulsed during RUN and GAP → ignored; frame count and timing unchanged.

Source files
------------

// File: rtl/loopback_controller.sv
// loopback_controller
//   Run sequencer for the 802.11a transmitter -> receiver loopback. An accepted
//   Go streams NumFrames PRBS payload frames into the transmitter, regenerates
//   the same PRBS to check the receiver output LOOP_LATENCY cycles later, and
//   accumulates bit / frame / receiver-error statistics.
//
// Ports
//   Clock, Reset      : single clock, synchronous active-high reset
//   Go                : one-shot run request, honoured only in IDLE
//   NumFrames, Seed   : run configuration, latched on an accepted Go
//   TxStart, TxInput  : transmitter Start pulse and serial payload
//   RxOutput, RxError : receiver serial output and error flag
//   Busy, Done, Pass  : run status (Done/Pass hold until the next accepted Go)
//   BitErrors         : mismatched bits this run (saturating)
//   FramesDone        : frames fully checked this run
//   FrameErrors       : frames with a mismatch or RxError (saturating)
module loopback_controller #(
  parameter int FRAME_BITS   = 96,
  parameter int LOOP_LATENCY = 64,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic [7:0]  NumFrames,
  input  logic [15:0] Seed,
  output logic        TxStart,
  output logic        TxInput,
  input  logic        RxOutput,
  input  logic        RxError,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [15:0] BitErrors,
  output logic [7:0]  FramesDone,
  output logic [7:0]  FrameErrors
);

  localparam int FRAME_CYCLES = LOOP_LATENCY + FRAME_BITS;
  localparam int CYC_W        = $clog2(FRAME_CYCLES + 1);
  localparam int GAP_W        = $clog2(GAP_CYCLES + 1);

  localparam logic [CYC_W-1:0] CYC_ZERO    = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] LAST_CYC    = CYC_W'(FRAME_CYCLES - 1);
  localparam logic [CYC_W-1:0] SEND_END    = CYC_W'(FRAME_BITS);
  localparam logic [CYC_W-1:0] CHECK_BEGIN = CYC_W'(LOOP_LATENCY);
  localparam logic [GAP_W-1:0] GAP_ZERO    = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [15:0]      DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // PRBS x^16+x^14+x^13+x^11+1, Fibonacci form, output taken from bit 15
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t             state_r, state_s;
  logic [CYC_W-1:0]   cyc_r, cyc_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic [7:0]         num_frames_r;
  logic [15:0]        tx_lfsr_r;
  logic [15:0]        chk_lfsr_r;
  logic               frame_bad_r;
  logic               tx_start_r, tx_input_r, busy_r, done_r, pass_r;
  logic [15:0]        bit_errors_r;
  logic [7:0]         frames_done_r, frame_errors_r;

  logic               go_accept_s;
  logic [15:0]        seed_eff_s;
  logic [15:0]        tx_src_s;
  logic               send_next_s;
  logic               in_check_s;
  logic               bit_mismatch_s;
  logic               frame_bad_s;
  logic               frame_end_s;

  assign TxStart     = tx_start_r;
  assign TxInput     = tx_input_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign Pass        = pass_r;
  assign BitErrors   = bit_errors_r;
  assign FramesDone  = frames_done_r;
  assign FrameErrors = frame_errors_r;

  // Next-state logic for the run sequencer and its frame/gap cycle counters
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    gap_s   = gap_r;
    case (state_r)
      ST_IDLE: begin
        if (Go) begin
          cyc_s = CYC_ZERO;
          if (NumFrames == 8'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cyc_r == LAST_CYC) begin
          state_s = ST_GAP;
          gap_s   = GAP_ZERO;
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          cyc_s = CYC_ZERO;
          // FramesDone already includes the frame that just finished
          if (frames_done_r == num_frames_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          gap_s = gap_r + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Per-cycle decode of the send/check windows and error conditions
  always_comb begin
    go_accept_s = (state_r == ST_IDLE) && Go;
    if (Seed == 16'h0000) begin
      seed_eff_s = DEFAULT_SEED;
    end else begin
      seed_eff_s = Seed;
    end
    if (go_accept_s) begin
      tx_src_s = seed_eff_s;
    end else begin
      tx_src_s = tx_lfsr_r;
    end
    // Outputs are registered, so the send window is decoded one cycle early
    send_next_s    = (state_s == ST_RUN) && (cyc_s < SEND_END);
    in_check_s     = (state_r == ST_RUN) && (cyc_r >= CHECK_BEGIN);
    bit_mismatch_s = in_check_s && (RxOutput != chk_lfsr_r[15]);
    frame_bad_s    = frame_bad_r || bit_mismatch_s || ((state_r == ST_RUN) && RxError);
    frame_end_s    = (state_r == ST_RUN) && (cyc_r == LAST_CYC);
  end

  // State and cycle counter registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cyc_r   <= CYC_ZERO;
      gap_r   <= GAP_ZERO;
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      gap_r   <= gap_s;
    end
  end

  // PRBS generators, registered outputs and run statistics
  always_ff @(posedge Clock) begin
    if (Reset) begin
      num_frames_r   <= 8'd0;
      tx_lfsr_r      <= DEFAULT_SEED;
      chk_lfsr_r     <= DEFAULT_SEED;
      frame_bad_r    <= 1'b0;
      tx_start_r     <= 1'b0;
      tx_input_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      bit_errors_r   <= 16'd0;
      frames_done_r  <= 8'd0;
      frame_errors_r <= 8'd0;
    end else begin
      tx_start_r <= (state_s == ST_RUN) && (cyc_s == CYC_ZERO);
      busy_r     <= (state_s == ST_RUN) || (state_s == ST_GAP);

      if (send_next_s) begin
        tx_input_r <= tx_src_s[15];
        tx_lfsr_r  <= lfsr_next(tx_src_s);
      end else begin
        tx_input_r <= 1'b0;
        tx_lfsr_r  <= tx_src_s;
      end

      if (go_accept_s) begin
        num_frames_r   <= NumFrames;
        chk_lfsr_r     <= seed_eff_s;
        frame_bad_r    <= 1'b0;
        bit_errors_r   <= 16'd0;
        frames_done_r  <= 8'd0;
        frame_errors_r <= 8'd0;
        // An empty run completes immediately and trivially passes
        done_r         <= (NumFrames == 8'd0);
        pass_r         <= (NumFrames == 8'd0);
      end else begin
        if (in_check_s) begin
          chk_lfsr_r <= lfsr_next(chk_lfsr_r);
        end
        if (bit_mismatch_s && (bit_errors_r != 16'hFFFF)) begin
          bit_errors_r <= bit_errors_r + 16'd1;
        end
        if (frame_end_s) begin
          frames_done_r <= frames_done_r + 8'd1;
          if (frame_bad_s && (frame_errors_r != 8'hFF)) begin
            frame_errors_r <= frame_errors_r + 8'd1;
          end
          frame_bad_r <= 1'b0;
        end else if (frame_bad_s) begin
          frame_bad_r <= 1'b1;
        end
        // Counters are final once the last frame has entered its gap
        if ((state_r == ST_GAP) && (state_s == ST_DONE)) begin
          done_r <= 1'b1;
          pass_r <= (bit_errors_r == 16'd0) && (frame_errors_r == 8'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_loopback_controller.sv
// tb_loopback_controller
//   Directed bench for loopback_controller with default parameters. A 64-cycle
//   delay line models an ideal transmitter/receiver pair; single-bit inversion
//   and RxError pulses are injected at chosen cycles of a run.
module tb_loopback_controller;

  localparam int FRAME_BITS = 96;
  localparam int LATENCY    = 64;
  localparam int GAP        = 16;
  localparam int PERIOD     = FRAME_BITS + LATENCY + GAP;

  logic        clk = 1'b0;
  logic        Reset, Go, RxOutput, RxError;
  logic [7:0]  NumFrames;
  logic [15:0] Seed;
  logic        TxStart, TxInput, Busy, Done, Pass;
  logic [15:0] BitErrors;
  logic [7:0]  FramesDone, FrameErrors;

  logic [LATENCY-1:0] tx_hist = {LATENCY{1'b0}};
  logic               flip = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  loopback_controller dut (
    .Clock(clk), .Reset(Reset), .Go(Go), .NumFrames(NumFrames), .Seed(Seed),
    .TxStart(TxStart), .TxInput(TxInput), .RxOutput(RxOutput), .RxError(RxError),
    .Busy(Busy), .Done(Done), .Pass(Pass), .BitErrors(BitErrors),
    .FramesDone(FramesDone), .FrameErrors(FrameErrors)
  );

  always #5 clk = ~clk;

  // ideal loop: TxInput delayed by LATENCY cycles, optionally inverted
  always @(posedge clk) tx_hist <= {tx_hist[LATENCY-2:0], TxInput};
  assign RxOutput = tx_hist[LATENCY-1] ^ flip;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Run one sequence; returns at the first DONE cycle (checked against timing)
  task automatic do_run(input logic [15:0] seed, input int nfr, input int flip_at,
                        input int rxerr_at, input int go_a, input int go_b);
    logic [15:0] m;
    int tx_bad, st_bad, busy_bad, done_i, c;
    logic exp_bit;
    m = (seed == 16'h0000) ? 16'hACE1 : seed;
    tx_bad = 0; st_bad = 0; busy_bad = 0; done_i = -1;
    @(negedge clk);
    Seed = seed; NumFrames = nfr[7:0]; Go = 1'b1;
    @(negedge clk);
    Go = 1'b0; Seed = 16'h1234; NumFrames = 8'd7;  // must not affect the run
    for (int i = 0; i <= nfr * PERIOD + 40; i++) begin
      if (i > 0) @(negedge clk);
      flip    = (i == flip_at);
      RxError = (i == rxerr_at);
      Go      = (i == go_a) || (i == go_b);
      if (Done === 1'b1) begin
        done_i = i;
        break;
      end
      c = i % PERIOD;
      if (TxStart !== (c == 0)) st_bad++;
      if (Busy !== 1'b1) busy_bad++;
      if (c < FRAME_BITS) begin
        exp_bit = m[15];
        m = lfsr_step(m);
      end else begin
        exp_bit = 1'b0;
      end
      if (TxInput !== exp_bit) tx_bad++;
    end
    flip = 1'b0; RxError = 1'b0; Go = 1'b0;
    check_eq("done_time", done_i, nfr * PERIOD);
    check_eq("tx_start_pattern", st_bad, 0);
    check_eq("tx_bit_errors", tx_bad, 0);
    check_eq("busy_during_run", busy_bad, 0);
  endtask

  // Result checks in the DONE cycle, then one cycle later (IDLE, held)
  task automatic check_result(input string tag, input int be, input int fd,
                              input int fe, input logic ps);
    check_eq({tag, "_bit_errors"}, BitErrors, be);
    check_eq({tag, "_frames_done"}, FramesDone, fd);
    check_eq({tag, "_frame_errors"}, FrameErrors, fe);
    check_eq({tag, "_pass"}, Pass, ps);
    check_eq({tag, "_busy_done"}, Busy, 0);
    check_eq({tag, "_txstart_done"}, TxStart, 0);
    @(negedge clk);
    check_eq({tag, "_done_held"}, Done, 1);
    check_eq({tag, "_pass_held"}, Pass, ps);
    check_eq({tag, "_frames_held"}, FramesDone, fd);
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; NumFrames = 8'd0; Seed = 16'h0000; RxError = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txstart", TxStart, 0);
    check_eq("rst_txinput", TxInput, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_pass", Pass, 0);
    check_eq("rst_bit_errors", BitErrors, 0);
    check_eq("rst_frames_done", FramesDone, 0);
    check_eq("rst_frame_errors", FrameErrors, 0);
    Reset = 1'b0;

    // ideal loopback, three frames
    do_run(16'h0001, 3, -1, -1, -1, -1);
    check_result("ideal", 0, 3, 0, 1'b1);

    // one inverted bit inside the check window of frame 2
    do_run(16'h0001, 3, PERIOD + LATENCY + 30, -1, -1, -1);
    check_result("bitflip", 1, 3, 1, 1'b0);

    // receiver error pulse in frame 1, data clean
    do_run(16'h0001, 3, -1, 10, -1, -1);
    check_result("rxerr", 0, 3, 1, 1'b0);

    // zero seed behaves as 16'hACE1 (TX bits checked against that model)
    do_run(16'h0000, 2, -1, -1, -1, -1);
    check_result("seed0", 0, 2, 0, 1'b1);

    // empty run
    do_run(16'h5A5A, 0, -1, -1, -1, -1);
    check_result("zero_frames", 0, 0, 0, 1'b1);

    // Go re-pulsed during RUN and during GAP
    do_run(16'hBEEF, 2, -1, -1, 50, 170);
    check_result("go_ignored", 0, 2, 0, 1'b1);

    // reset in the middle of frame 2 of 4
    @(negedge clk);
    Seed = 16'h0005; NumFrames = 8'd4; Go = 1'b1;
    @(negedge clk);
    Go = 1'b0;
    repeat (250) @(negedge clk);
    check_eq("midrun_frames_done", FramesDone, 1);
    check_eq("midrun_busy", Busy, 1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check_eq("reset_busy", Busy, 0);
    check_eq("reset_txstart", TxStart, 0);
    check_eq("reset_txinput", TxInput, 0);
    check_eq("reset_frames_done", FramesDone, 0);
    check_eq("reset_done", Done, 0);
    do_run(16'h0005, 4, -1, -1, -1, -1);
    check_result("after_reset", 0, 4, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
